// File: rtl/pipelined_cia_adder.sv
// Streaming carry-increment adder/subtractor that resolves one BLOCK-bit slice per pipeline stage.
// Build option: define PIPELINED_CIA_ADDER_SAT_EN for a signed saturating sum.

module cia_slice #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co
);
    logic [BLOCK-1:0] raw;
    logic [BLOCK:0]   rc;
    logic [BLOCK:0]   ic;

    // Ripple at carry 0, then fold the incoming carry in through a half-adder chain.
    always_comb begin
        raw = '0;
        rc  = '0;
        ic  = '0;
        s   = '0;
        co  = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            raw[i]  = a[i] ^ b[i] ^ rc[i];
            rc[i+1] = (a[i] & b[i]) | (rc[i] & (a[i] ^ b[i]));
        end
        ic[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            s[i]    = raw[i] ^ ic[i];
            ic[i+1] = raw[i] & ic[i];
        end
        co = rc[BLOCK] | ic[BLOCK];
    end
endmodule

module pipelined_cia_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);
    localparam int NBLK = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_bad_width
        $error("pipelined_cia_adder: WIDTH must be a multiple of BLOCK");
    end

    // s holds the slices resolved so far; a/bx travel whole so the final stage can judge overflow.
    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic             c;
    } stg_t;

    stg_t          stg_in [NBLK];
    stg_t          stg_q  [NBLK];
    logic [NBLK:0] vld_pipe;
    logic          stall;
    logic          of_w;

    assign out_valid   = vld_pipe[NBLK];
    assign stall       = out_valid & ~out_ready;
    assign in_ready    = ~stall;
    assign vld_pipe[0] = in_valid;

    assign stg_in[0] = '{s: '0, a: a, bx: (sub ? ~b : b), c: (sub | cin)};

    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe[NBLK:1] <= '0;
        else if (!stall)
            vld_pipe[NBLK:1] <= vld_pipe[NBLK-1:0];
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        logic [BLOCK-1:0] s_k;
        logic             c_nxt;
        stg_t             nxt;

        if (k > 0) begin : g_fwd
            assign stg_in[k] = stg_q[k-1];
        end

        cia_slice #(.BLOCK(BLOCK)) u_slice (
            .a  (stg_in[k].a[k*BLOCK +: BLOCK]),
            .b  (stg_in[k].bx[k*BLOCK +: BLOCK]),
            .ci (stg_in[k].c),
            .s  (s_k),
            .co (c_nxt)
        );

        always_comb begin
            nxt                     = stg_in[k];
            nxt.s[k*BLOCK +: BLOCK] = s_k;
            nxt.c                   = c_nxt;
        end

        always_ff @(posedge clk) begin
            if (rst)
                stg_q[k] <= '0;
            else if (!stall)
                stg_q[k] <= nxt;
        end
    end

    assign of_w = (stg_q[NBLK-1].s[WIDTH-1] ^ stg_q[NBLK-1].a[WIDTH-1])
                & ~(stg_q[NBLK-1].a[WIDTH-1] ^ stg_q[NBLK-1].bx[WIDTH-1]);
    assign of   = of_w;
    assign cout = stg_q[NBLK-1].c;

`ifdef PIPELINED_CIA_ADDER_SAT_EN
    // Clamp toward the sign of A: positive overflow gives max, negative gives min.
    assign sum = of_w ? {stg_q[NBLK-1].a[WIDTH-1], {(WIDTH-1){~stg_q[NBLK-1].a[WIDTH-1]}}}
                      : stg_q[NBLK-1].s;
`else
    assign sum = stg_q[NBLK-1].s;
`endif

endmodule

// File: tb/tb_pipelined_cia_adder.sv
// Self-checking bench for pipelined_cia_adder: directed table, stall/reset sequences, random vs model.
module tb_pipelined_cia_adder;
    localparam int NBLK = 4;

`ifdef PIPELINED_CIA_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        of;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        of;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0, sum;
    logic        cin = 1'b0, sub = 1'b0, cout, of;

    logic        in_valid16 = 1'b0, in_ready16, out_valid16;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        cin16 = 1'b0, sub16 = 1'b0, cout16, of16;

    int   n_cmp = 0;
    int   n_err = 0;
    int   retired = 0;
    bit   done = 1'b0;
    res_t exp_q[$];
    res_t mon_e;

    always #5 clk = ~clk;

    pipelined_cia_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .of(of)
    );

    pipelined_cia_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(1'b1),
        .sum(sum16), .cout(cout16), .of(of16)
    );

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic ci, input logic sb);
        res_t        r;
        logic [63:0] mask, am, bx, tot, c0;
        longint      lim, sa, sbx, st;
        mask = (64'd1 << w) - 64'd1;
        am   = av & mask;
        bx   = (sb ? ~bv : bv) & mask;
        c0   = (sb || ci) ? 64'd1 : 64'd0;
        tot  = am + bx + c0;
        lim  = longint'(64'd1 << (w - 1));
        sa   = am[w-1] ? longint'(am) - 2 * lim : longint'(am);
        sbx  = bx[w-1] ? longint'(bx) - 2 * lim : longint'(bx);
        st   = sa + sbx + longint'(c0);
        r.sum  = tot & mask;
        r.cout = tot[w];
        r.of   = (st >= lim) || (st < -lim);
        if (SAT && r.of)
            r.sum = (sa < 0) ? 64'(lim) : 64'(lim - 1);
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard for the 32-bit instance; handshakes are judged at the negedge before the edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                retired++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got sum=%h cout=%b of=%b with nothing pending", sum, cout, of);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (sum !== mon_e.sum[31:0] || cout !== mon_e.cout || of !== mon_e.of) begin
                        n_err++;
                        $display("FAIL sb_result: got %h/%b/%b expected %h/%b/%b",
                                 sum, cout, of, mon_e.sum[31:0], mon_e.cout, mon_e.of);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(32, 64'(a), 64'(b), cin, sub));
        end
    end

    // Single op into an idle pipeline; checks latency and value. Entry/exit at posedge+1.
    task automatic run_one(input string nm, input logic [31:0] av, input logic [31:0] bv,
                           input logic ci, input logic sb,
                           input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk({nm, "_lat"}, 64'(lat), 64'(NBLK));
        chk({nm, "_sum"}, 64'(sum), 64'(es));
        chk({nm, "_cout"}, 64'(cout), 64'(ec));
        chk({nm, "_of"}, 64'(of), 64'(eo));
        @(posedge clk); #1;
    endtask

    task automatic run16(input string nm, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb,
                         input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        a16 = av; b16 = bv; cin16 = ci; sub16 = sb; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid16 && lat < 20);
        chk({nm, "_lat"}, 64'(lat), 64'(NBLK));
        chk({nm, "_sum"}, 64'(sum16), 64'(es));
        chk({nm, "_cout"}, 64'(cout16), 64'(ec));
        chk({nm, "_of"}, 64'(of16), 64'(eo));
        @(posedge clk); #1;
    endtask

    // Present operands and hold them until accepted.
    task automatic send_hold(input logic [31:0] av, input logic [31:0] bv,
                             input logic ci, input logic sb);
        int g;
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        g = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            if (g >= 50) break;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int g;
        in_valid = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vt[8];
        res_t e;
        int   base, seen;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_of", 64'(of), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_in_ready16", 64'(in_ready16), 64'd1);
        @(posedge clk); #1;

        vt[0] = '{a: 32'hFFFF_FFFF, b: 32'h1, cin: 1'b0, sub: 1'b0, sum: 32'h0, cout: 1'b1, of: 1'b0};
        vt[1] = '{a: 32'h7FFF_FFFF, b: 32'h1, cin: 1'b0, sub: 1'b0,
                  sum: (SAT ? 32'h7FFF_FFFF : 32'h8000_0000), cout: 1'b0, of: 1'b1};
        vt[2] = '{a: 32'h5, b: 32'h7, cin: 1'b1, sub: 1'b1, sum: 32'hFFFF_FFFE, cout: 1'b0, of: 1'b0};
        vt[3] = '{a: 32'h8000_0000, b: 32'h1, cin: 1'b0, sub: 1'b1,
                  sum: (SAT ? 32'h8000_0000 : 32'h7FFF_FFFF), cout: 1'b1, of: 1'b1};
        vt[4] = '{a: 32'hFFFF_FFFF, b: 32'h0, cin: 1'b1, sub: 1'b0, sum: 32'h0, cout: 1'b1, of: 1'b0};
        vt[5] = '{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b0, sub: 1'b0,
                  sum: (SAT ? 32'h8000_0000 : 32'h0), cout: 1'b1, of: 1'b1};
        vt[6] = '{a: 32'h3, b: 32'h3, cin: 1'b0, sub: 1'b1, sum: 32'h0, cout: 1'b1, of: 1'b0};
        vt[7] = '{a: 32'h1234_5678, b: 32'h1111_1111, cin: 1'b1, sub: 1'b0,
                  sum: 32'h2345_678A, cout: 1'b0, of: 1'b0};
        for (int i = 0; i < 8; i++)
            run_one($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].sub,
                    vt[i].sum, vt[i].cout, vt[i].of);

        run16("w16_dir", 16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra, rb;
            logic        rc, rs;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            e = model(16, 64'(ra), 64'(rb), rc, rs);
            run16($sformatf("w16_rnd%0d", i), ra, rb, rc, rs, e.sum[15:0], e.cout, e.of);
        end

        // Six back-to-back ops, results 2..4 see out_ready low for three cycles.
        base = retired;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_hold(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                int g;
                logic [31:0] hs;
                logic hc, ho;
                g = 0;
                forever begin
                    @(negedge clk);
                    g++;
                    if ((out_valid && out_ready) || g >= 40) break;
                end
                chk("stall_first_out", 64'(g < 40), 64'd1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                hs = sum; hc = cout; ho = of;
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                for (int c = 0; c < 3; c++) begin
                    if (c > 0) @(negedge clk);
                    chk($sformatf("stall_in_ready%0d", c), 64'(in_ready), 64'd0);
                    chk($sformatf("stall_hold_sum%0d", c), 64'(sum), 64'(hs));
                    chk($sformatf("stall_hold_flags%0d", c), 64'({cout, of}), 64'({hc, ho}));
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("stall");
        chk("stall_count", 64'(retired - base), 64'd6);

        // Reset with three ops in flight: nothing stale may emerge.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            send_hold($urandom, $urandom, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_flags", 64'({cout, of}), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_rst_no_stale", 64'(seen), 64'd0);
        @(posedge clk); #1;
        run_one("post_rst", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);

        // Random traffic with bubbles and random backpressure.
        base = retired;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send_hold(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        drain("rand");
        chk("rand_count", 64'(retired - base), 64'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipelined_cia_adder.md
Name: pipelined_cia_adder

Overview:
- Parametrised, pipelined carry-increment adder/subtractor. It is the streaming successor of the team's combinational 32-bit carry-increment adder.
- Operands are split into BLOCK-bit slices. Each slice is added with ripple-carry logic at carry-in 0, then corrected by a half-adder increment chain driven by the previous slice's carry.
- There is one register stage per slice, so the block sustains one operation per clock.
- A valid/ready handshake on both sides lets it sit between the register-file read stage and the writeback buffer of the ALU datapath.

Parameters:
- WIDTH, 32: operand and result width. Must be a multiple of BLOCK; elaboration fails otherwise.
- BLOCK, 8: slice width, and the bits resolved per pipeline stage.
- NBLK, WIDTH/BLOCK (derived localparam, not overridable): number of stages, which equals the latency.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands are presented.
- in_ready  output  1  block accepts the operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Ignored when sub=1.
- sub  input  1  0 gives A+B+cin; 1 gives A-B, computed as A+~B+1.
- out_valid  output  1  result is presented.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1. For sub, 1 means no borrow.
- of  output  1  signed two's-complement overflow.

Behaviour:
- Reset: on rst=1 at a clock edge, all stage valid bits clear. Next cycle out_valid=0, sum=0, cout=0, of=0, in_ready=1. Any in-flight operations are discarded. rst has priority over every other input.
- Effective operand: bx = sub ? ~b : b, and c0 = sub ? 1 : cin. Both are captured at acceptance.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall.
  - The whole pipeline advances only when stall=0.
  - While stalled, every stage register holds its value and sum/cout/of are held stable.
- Accept: an operation is accepted when in_valid & in_ready. in_valid with in_ready=0 is not accepted; the source must hold its operands.
- Stage k (0..NBLK-1): slice s_k = a_k + bx_k at carry 0, producing raw carry g_k. Stage k then increments s_k by carry c_k through a half-adder chain, producing increment carry p_k. Carry out c_{k+1} = p_k | g_k.
  - Stage 0 uses c0.
  - Stage k>0 uses c_k held in the stage k-1 register.
  - Each stage register carries the already-resolved low slices forward, plus the remaining high operand slices.
- Latency: an operation accepted in cycle t has out_valid=1 in cycle t+NBLK, absent stalls. Each stall cycle adds one cycle.
- Throughput: one operation per cycle. Bubbles, i.e. cycles with in_valid=0, propagate as invalid stages. Results leave in acceptance order.
- cout = c_NBLK.
- of = (sum[W-1] ^ a[W-1]) & ~(a[W-1] ^ bx[W-1]), where a and bx are the values captured with the operation.
- Simultaneous events:
  - With a full pipeline and out_ready=1, accepting a new operation and retiring the oldest happen in the same cycle.
  - out_ready=1 while out_valid=0 has no effect.
- Wrap-around: sum is modulo 2^WIDTH. Overflow is reported only via cout and of.

Optional Feature:
- Macro: PIPELINED_CIA_ADDER_SAT_EN.
- Defined: signed saturating output. When of=1, sum is 2^(W-1)-1 if a[W-1]=0, and -2^(W-1) if a[W-1]=1. cout and of still report the unsaturated result. Saturation is applied in the final stage and does not change latency.
- Undefined: sum is the wrapped result. No saturation logic is generated.

Test Plan:
- WIDTH=32, BLOCK=8, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 4 cycles later sum=0x00000000, cout=1, of=0. This exercises the full increment ripple across all slices.
- a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, of=1. With PIPELINED_CIA_ADDER_SAT_EN defined, sum=0x7FFFFFFF and of=1.
- a=5, b=7, sub=1, cin=1 (cin ignored) -> sum=0xFFFFFFFE, cout=0, of=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, of=1.
- Six back-to-back operations with out_ready=0 on output cycles 2-4 -> in_ready=0 while stalled, outputs held stable, all six results appear exactly once in order.
- Three operations in flight, rst=1 for one cycle -> out_valid=0 from the next cycle, no stale result ever appears. A fresh operation (1+2) returns 3 at latency 4.
- WIDTH=16, BLOCK=4, a=0x0FFF, b=0x0001, cin=1 -> sum=0x1001, cout=0, of=0 at latency 4.
